aes_key_arbiter: RTL and testbench
==================================

AES_KEY_ARBITER -- requirements
Module: aes_key_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one key expansion engine (2..8).
REQ-002 Parameter KEY_WIDTH, default 256, AES key width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 511, maximum cycles to wait for expansion completion.
REQ-004 Derived OWNER_W SHALL equal max(1, clog2(NUM_REQ)).
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_i  input  NUM_REQ  per-requester level request; held with a stable key until that requester's gnt_o pulse.
REQ-008 req_key_i  input  NUM_REQ*KEY_WIDTH  flat key bus; requester n occupies bits [n*KEY_WIDTH +: KEY_WIDTH].
REQ-009 gnt_o  output  NUM_REQ  one-hot, one-cycle completion pulse per request.
REQ-010 gnt_err_o  output  1  high in the same cycle as gnt_o when the request timed out.
REQ-011 owner_o  output  OWNER_W  index of the requester whose key is loaded in the engine.
REQ-012 owner_valid_o  output  1  engine round keys are valid for owner_o.
REQ-013 ke_key_o  output  KEY_WIDTH  key driven to the expansion engine.
REQ-014 ke_key_valid_o  output  1  level key-valid to the engine; the engine starts on its rising edge and holds its keys while it stays high.
REQ-015 ke_keys_valid_i  input  1  engine round-keys-valid.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, HOLD and RELEASE.
REQ-017 Eligible request: req_i[n] high and gnt_o[n] not high in the previous cycle.
REQ-018 Arbitration SHALL be round-robin; after reset requester 0 has priority; after any grant, priority moves to (granted index + 1) mod NUM_REQ.
REQ-019 IDLE, any eligible request: latch the winner key into ke_key_o and the winner index as pending; set ke_key_valid_o=1; clear the timeout counter; go to WAIT.
REQ-020 WAIT: the counter SHALL increment each cycle.
REQ-021 WAIT, ke_keys_valid_i=1: pulse gnt_o[pending] next cycle; set owner_o=pending; record the loaded-key tag (ke_key_o) as valid; go to HOLD.
REQ-022 WAIT, counter reaches TIMEOUT_CYCLES with no ke_keys_valid_i: pulse gnt_o[pending] and gnt_err_o together; set ke_key_valid_o=0; invalidate the tag; go to RELEASE.
REQ-023 If ke_keys_valid_i and timeout occur in the same cycle, completion SHALL win.
REQ-024 owner_valid_o SHALL equal (state==HOLD) AND ke_keys_valid_i.
REQ-025 HOLD, eligible winner key equals the tag (hit): pulse its gnt_o next cycle; update owner_o; keep ke_key_valid_o=1; no re-expansion.
REQ-026 HOLD, eligible winner key differs (miss): set ke_key_valid_o=0; invalidate the tag; go to RELEASE without granting.
REQ-027 The winner of a miss SHALL keep priority for the following IDLE arbitration.
REQ-028 RELEASE SHALL last exactly 2 cycles with ke_key_valid_o=0, then go to IDLE.
REQ-029 In HOLD with no eligible request, the block SHALL stay in HOLD with ke_key_valid_o=1.
REQ-030 Requests arriving in WAIT or RELEASE SHALL stay pending, never be dropped, and arbitrate at the next IDLE or HOLD evaluation.
REQ-031 At most one gnt_o bit SHALL be high in any cycle.

Reset
REQ-032 Under rst: state=IDLE; gnt_o=0; gnt_err_o=0; owner_o=0; owner_valid_o=0; ke_key_valid_o=0; ke_key_o=0; tag invalid; counter=0; priority=requester 0.
REQ-033 rst asserted in any state, including mid-WAIT, SHALL abort without a grant; the aborted requester re-arbitrates after reset.

Verification
REQ-034 Single request: req_i=01, key K0, engine valid 104 cycles after ke_key_valid_o -> gnt_o=01 one cycle later; owner_o=0; owner_valid_o=1; gnt_err_o=0.
REQ-035 Simultaneous req_i=11, distinct keys, from reset -> grant order requester 0 then 1; ke_key_valid_o low exactly 2 cycles between the two expansions.
REQ-036 Hit: requester 1 requests the key already loaded in HOLD -> gnt_o=10 within 2 cycles; ke_key_valid_o never drops; owner_o changes 0->1.
REQ-037 Timeout: engine never asserts valid, TIMEOUT_CYCLES=511 -> gnt_o and gnt_err_o pulse together; ke_key_valid_o=0; RELEASE 2 cycles; then IDLE.
REQ-038 Completion and timeout in the same cycle -> normal grant, gnt_err_o=0.
REQ-039 rst pulsed mid-WAIT -> all outputs at reset values the next cycle; no gnt_o; the request is re-issued after rst deasserts.

Source files
------------

// File: rtl/aes_key_arbiter_if.sv
// Handshake bundle between the key requesters, the arbiter and the
// AES key expansion engine.
interface aes_key_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int KEY_WIDTH = 256
);
    localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_i;
    logic [NUM_REQ*KEY_WIDTH-1:0] req_key_i;
    logic [NUM_REQ-1:0]           gnt_o;
    logic                         gnt_err_o;
    logic [OWNER_W-1:0]           owner_o;
    logic                         owner_valid_o;
    logic [KEY_WIDTH-1:0]         ke_key_o;
    logic                         ke_key_valid_o;
    logic                         ke_keys_valid_i;

    // Requester / engine side of the bundle
    modport master (
        output req_i,
        output req_key_i,
        output ke_keys_valid_i,
        input  gnt_o,
        input  gnt_err_o,
        input  owner_o,
        input  owner_valid_o,
        input  ke_key_o,
        input  ke_key_valid_o
    );

    // Arbiter side of the bundle
    modport slave (
        input  req_i,
        input  req_key_i,
        input  ke_keys_valid_i,
        output gnt_o,
        output gnt_err_o,
        output owner_o,
        output owner_valid_o,
        output ke_key_o,
        output ke_key_valid_o
    );
endinterface

// File: rtl/aes_key_arbiter.sv
// Round-robin arbiter sharing one AES key expansion engine between
// NUM_REQ requesters. A key already expanded in the engine is reused
// (HOLD hit) without re-expansion; a different key forces a release.
module aes_key_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int KEY_WIDTH      = 256,
    parameter int TIMEOUT_CYCLES = 511
) (
    input  logic             clk,
    input  logic             rst,
    aes_key_arbiter_if.slave bus
);
    localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 kv_q, kv_d;
    logic                 tag_valid_q, tag_valid_d;
    logic [OWNER_W-1:0]   pend_q, pend_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   prio_q, prio_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rel_q, rel_d;

    logic [NUM_REQ-1:0]   elig_s;
    logic                 win_vld_s;
    logic [OWNER_W-1:0]   win_idx_s;
    logic [KEY_WIDTH-1:0] win_key_s;
    logic                 hit_s;
    logic                 timeout_s;
    logic                 arb_now_s;
    logic [OWNER_W:0]     cand_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] idx);
        return (idx == OWNER_W'(NUM_REQ - 1)) ? OWNER_W'(0) : idx + OWNER_W'(1);
    endfunction

    // Round-robin winner search starting at prio_q; lowest offset wins
    always_comb begin
        cand_s    = '0;
        elig_s    = bus.req_i & ~gnt_q;
        win_vld_s = |elig_s;
        win_idx_s = prio_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s    = {1'b0, prio_q} + (OWNER_W + 1)'(i);
            cand_s    = (cand_s >= (OWNER_W + 1)'(NUM_REQ)) ? cand_s - (OWNER_W + 1)'(NUM_REQ) : cand_s;
            win_idx_s = elig_s[cand_s[OWNER_W-1:0]] ? cand_s[OWNER_W-1:0] : win_idx_s;
        end
        win_key_s = bus.req_key_i[KEY_WIDTH-1:0];
        for (int i = 1; i < NUM_REQ; i++) begin
            win_key_s = (win_idx_s == OWNER_W'(i)) ? bus.req_key_i[i*KEY_WIDTH +: KEY_WIDTH] : win_key_s;
        end
        hit_s     = tag_valid_q && (win_key_s == key_q);
        timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
        // The closing cycle of RELEASE doubles as the IDLE evaluation so the
        // engine sees its key-valid low for exactly two cycles.
        arb_now_s = (state_q == ST_IDLE) || ((state_q == ST_RELEASE) && rel_q);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            kv_q        <= 1'b0;
            tag_valid_q <= 1'b0;
            pend_q      <= '0;
            owner_q     <= '0;
            prio_q      <= '0;
            gnt_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            kv_q        <= kv_d;
            tag_valid_q <= tag_valid_d;
            pend_q      <= pend_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = win_vld_s ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.ke_keys_valid_i) begin
                    state_d = ST_HOLD;
                end else if (timeout_s) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                state_d = (win_vld_s && !hit_s) ? ST_RELEASE : ST_HOLD;
            end
            ST_RELEASE: begin
                if (arb_now_s) begin
                    state_d = win_vld_s ? ST_WAIT : ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered output updates for each state
    always_comb begin
        key_d       = key_q;
        kv_d        = kv_q;
        tag_valid_d = tag_valid_q;
        pend_d      = pend_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        gnt_d       = '0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        rel_d       = 1'b0;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                rel_d = (state_q == ST_RELEASE) ? ~rel_q : 1'b0;
                if (arb_now_s && win_vld_s) begin
                    key_d  = win_key_s;
                    pend_d = win_idx_s;
                    kv_d   = 1'b1;
                    cnt_d  = '0;
                    rel_d  = 1'b0;
                end else begin
                    kv_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.ke_keys_valid_i) begin
                    gnt_d       = onehot(pend_q);
                    owner_d     = pend_q;
                    tag_valid_d = 1'b1;
                    prio_d      = next_idx(pend_q);
                end else if (timeout_s) begin
                    gnt_d       = onehot(pend_q);
                    err_d       = 1'b1;
                    kv_d        = 1'b0;
                    tag_valid_d = 1'b0;
                    prio_d      = next_idx(pend_q);
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (win_vld_s && hit_s) begin
                    gnt_d       = onehot(win_idx_s);
                    owner_d     = win_idx_s;
                    prio_d      = next_idx(win_idx_s);
                end else if (win_vld_s) begin
                    // Miss: the winner keeps priority for the next expansion
                    kv_d        = 1'b0;
                    tag_valid_d = 1'b0;
                    prio_d      = win_idx_s;
                end else begin
                    kv_d        = 1'b1;
                end
            end
            default: begin
                kv_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt_o          = gnt_q;
    assign bus.gnt_err_o      = err_q;
    assign bus.owner_o        = owner_q;
    assign bus.ke_key_o       = key_q;
    assign bus.ke_key_valid_o = kv_q;
    assign bus.owner_valid_o  = (state_q == ST_HOLD) && bus.ke_keys_valid_i;
endmodule

// File: tb/tb_aes_key_arbiter.sv
// Directed bench for aes_key_arbiter with a behavioural expansion engine
// whose round-key latency is set per test.
`timescale 1ns/1ps
module tb_aes_key_arbiter;
    localparam int NUM_REQ        = 2;
    localparam int KEY_WIDTH      = 256;
    localparam int TIMEOUT_CYCLES = 511;
    localparam int NEVER          = 100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_arbiter_if #(.NUM_REQ(NUM_REQ), .KEY_WIDTH(KEY_WIDTH)) bus ();

    aes_key_arbiter #(
        .NUM_REQ(NUM_REQ),
        .KEY_WIDTH(KEY_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int eng_lat = NEVER;
    int eng_cnt = 0;
    int n, lows;
    logic [KEY_WIDTH-1:0] k0, k1, k2;

    // Engine model: round keys valid eng_lat cycles after key-valid rises
    always @(negedge clk) begin
        if (bus.ke_key_valid_o === 1'b1) begin
            bus.ke_keys_valid_i = (eng_cnt >= eng_lat);
            eng_cnt = eng_cnt + 1;
        end else begin
            bus.ke_keys_valid_i = 1'b0;
            eng_cnt = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [KEY_WIDTH-1:0] got, input logic [KEY_WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_i = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_kv(input int bound);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (bus.ke_key_valid_o !== 1'b1 && c < bound);
        check_eq("kv_rise", bus.ke_key_valid_o, 1'b1);
    endtask

    task automatic wait_gnt(input int bound, output int cyc, output int klow);
        cyc  = 0;
        klow = 0;
        do begin
            tick();
            cyc++;
            if (bus.ke_key_valid_o !== 1'b1) klow++;
        end while (bus.gnt_o === '0 && cyc < bound);
    endtask

    initial begin
        k0 = {8{32'h0123_4567}};
        k1 = {8{32'h89AB_CDEF}};
        k2 = {4{64'hDEAD_BEEF_0000_1111}};
        bus.req_i     = '0;
        bus.req_key_i = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_gnt",   bus.gnt_o,          2'b00);
        check_eq("rst_err",   bus.gnt_err_o,      1'b0);
        check_eq("rst_owner", bus.owner_o,        1'b0);
        check_eq("rst_ov",    bus.owner_valid_o,  1'b0);
        check_eq("rst_kv",    bus.ke_key_valid_o, 1'b0);
        check_eq("rst_key",   bus.ke_key_o,       256'd0);
        rst = 1'b0;
        tick();

        // Single request, engine latency 104
        eng_lat       = 104;
        bus.req_key_i = {k1, k0};
        bus.req_i     = 2'b01;
        wait_kv(4);
        check_eq("single_key", bus.ke_key_o, k0);
        wait_gnt(200, n, lows);
        check_eq("single_gnt",   bus.gnt_o,         2'b01);
        check_eq("single_err",   bus.gnt_err_o,     1'b0);
        check_eq("single_owner", bus.owner_o,       1'b0);
        check_eq("single_ov",    bus.owner_valid_o, 1'b1);
        check_eq("single_lat",   n,                 105);
        bus.req_i = 2'b00;
        tick();
        check_eq("single_pulse", bus.gnt_o, 2'b00);

        // Hit: requester 1 asks for the key already expanded
        bus.req_key_i = {k0, k0};
        bus.req_i     = 2'b10;
        wait_gnt(2, n, lows);
        check_eq("hit_gnt",   bus.gnt_o,     2'b10);
        check_eq("hit_kvlow", lows,          0);
        check_eq("hit_owner", bus.owner_o,   1'b1);
        check_eq("hit_err",   bus.gnt_err_o, 1'b0);
        bus.req_i = 2'b00;
        tick();
        check_eq("hit_hold_kv", bus.ke_key_valid_o, 1'b1);

        // Simultaneous requests, distinct keys, from reset
        do_reset();
        eng_lat       = 20;
        bus.req_key_i = {k1, k0};
        bus.req_i     = 2'b11;
        wait_kv(4);
        check_eq("dual_key0", bus.ke_key_o, k0);
        wait_gnt(100, n, lows);
        check_eq("dual_gnt0", bus.gnt_o, 2'b01);
        bus.req_i = 2'b10;
        wait_gnt(100, n, lows);
        check_eq("dual_gnt1",   bus.gnt_o,     2'b10);
        check_eq("dual_kvlow",  lows,          2);
        check_eq("dual_key1",   bus.ke_key_o,  k1);
        check_eq("dual_owner1", bus.owner_o,   1'b1);
        check_eq("dual_err",    bus.gnt_err_o, 1'b0);
        bus.req_i = 2'b00;

        // Timeout: engine never completes
        do_reset();
        eng_lat       = NEVER;
        bus.req_key_i = {k1, k2};
        bus.req_i     = 2'b01;
        wait_kv(4);
        check_eq("to_key", bus.ke_key_o, k2);
        wait_gnt(600, n, lows);
        check_eq("to_gnt", bus.gnt_o,          2'b01);
        check_eq("to_err", bus.gnt_err_o,      1'b1);
        check_eq("to_kv",  bus.ke_key_valid_o, 1'b0);
        check_eq("to_lat", n,                  512);
        check_eq("to_ov",  bus.owner_valid_o,  1'b0);
        bus.req_i = 2'b00;
        tick();
        check_eq("to_pulse",  bus.gnt_o | {1'b0, bus.gnt_err_o}, 2'b00);
        check_eq("to_rel_kv", bus.ke_key_valid_o, 1'b0);
        tick();
        tick();
        check_eq("to_idle_kv", bus.ke_key_valid_o, 1'b0);
        eng_lat   = 5;
        bus.req_i = 2'b10;
        wait_kv(4);
        check_eq("to_next_key", bus.ke_key_o, k1);
        wait_gnt(50, n, lows);
        check_eq("to_next_gnt", bus.gnt_o,     2'b10);
        check_eq("to_next_err", bus.gnt_err_o, 1'b0);
        bus.req_i = 2'b00;

        // Completion and timeout in the same cycle: completion wins
        do_reset();
        eng_lat       = 511;
        bus.req_key_i = {k1, k0};
        bus.req_i     = 2'b01;
        wait_kv(4);
        wait_gnt(600, n, lows);
        check_eq("tie_gnt", bus.gnt_o,          2'b01);
        check_eq("tie_err", bus.gnt_err_o,      1'b0);
        check_eq("tie_lat", n,                  512);
        check_eq("tie_kv",  bus.ke_key_valid_o, 1'b1);
        bus.req_i = 2'b00;

        // Reset pulsed mid-WAIT aborts, request re-arbitrates afterwards
        do_reset();
        eng_lat       = 50;
        bus.req_key_i = {k1, k0};
        bus.req_i     = 2'b01;
        wait_kv(4);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_gnt", bus.gnt_o,          2'b00);
        check_eq("mid_rst_err", bus.gnt_err_o,      1'b0);
        check_eq("mid_rst_kv",  bus.ke_key_valid_o, 1'b0);
        check_eq("mid_rst_key", bus.ke_key_o,       256'd0);
        check_eq("mid_rst_ov",  bus.owner_valid_o,  1'b0);
        rst = 1'b0;
        wait_kv(4);
        wait_gnt(100, n, lows);
        check_eq("reissue_gnt", bus.gnt_o,     2'b01);
        check_eq("reissue_err", bus.gnt_err_o, 1'b0);
        check_eq("reissue_lat", n,             51);
        bus.req_i = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
